// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state to the state enum.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int WORD_BYTES     = 4;
    // Stream order: first data byte of each word lands in bits [31:24].
    localparam bit WORD_MSB_FIRST = 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_WRITE, ST_DONE, ST_ERROR, ST_CHECK
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_WRITE, ST_DONE, ST_ERROR
    } loader_state_t;
`endif

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  byte_data, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output byte_data, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes into a 32-bit word; word_full_o flags the
// shift that completes the current word.
module imem_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);
    localparam int CW = $clog2(WORD_BYTES);

    logic [31:0]   word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en_i) begin
            word_d = WORD_MSB_FIRST ? {word_q[23:0], byte_i} : {byte_i, word_q[31:8]};
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_en_i && (cnt_q == CW'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header count + big-endian words streamed into imem, CPU held
// in reset until the image is complete. IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = HDR_BYTES * 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam logic [CNT_W:0] CAPACITY = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        hdr_hi_q, hdr_hi_d;
    logic [CNT_W-1:0]  n_q, n_d, hdr_n;
    logic              ready_c, accept, we_c, asm_clear, start_load, word_full, last_word;
    logic [31:0]       word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    always_comb begin
        ready_c = 1'b0;
        case (state_q)
            ST_HDR_HI, ST_HDR_LO, ST_DATA: ready_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK:                      ready_c = 1'b1;
`endif
            default:                       ready_c = 1'b0;
        endcase
        if (reset) ready_c = 1'b0;
    end

    assign accept    = ready_c && bus.byte_valid;
    assign hdr_n     = CNT_W'({hdr_hi_q, bus.byte_data});
    // Terminal compare happens before the increment, so a full image never wraps idx.
    assign last_word = CNT_W'(idx_q) == (n_q - CNT_W'(1));

    imem_byte_assembler u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (asm_clear),
        .shift_en_i  (accept && (state_q == ST_DATA)),
        .byte_i      (bus.byte_data),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hdr_hi_d   = hdr_hi_q;
        n_d        = n_q;
        asm_clear  = 1'b0;
        we_c       = 1'b0;
        start_load = 1'b0;
        busy       = 1'b1;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = accept ? sum_q + bus.byte_data : sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy       = 1'b0;
                start_load = start;
            end
            ST_HDR_HI: if (accept) begin
                hdr_hi_d = bus.byte_data;
                state_d  = ST_HDR_LO;
            end
            ST_HDR_LO: if (accept) begin
                n_d = hdr_n;
                if (hdr_n == '0 || {1'b0, hdr_n} > CAPACITY) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d   = ST_DATA;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_DATA: if (word_full) state_d = ST_WRITE;
            ST_WRITE: begin
                we_c = !reset;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: if (accept) state_d = (sum_d == 8'h00) ? ST_DONE : ST_ERROR;
`endif
            ST_DONE: begin
                busy       = 1'b0;
                cpu_reset  = 1'b0;
                done       = 1'b1;
                start_load = start;
            end
            ST_ERROR: begin
                busy       = 1'b0;
                error      = 1'b1;
                start_load = start;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_load) begin
            state_d   = ST_HDR_HI;
            idx_d     = '0;
            asm_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hdr_hi_q <= '0;
            n_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hdr_hi_q <= hdr_hi_d;
            n_q      <= n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign bus.byte_ready = ready_c;
    assign bus.imem_we    = we_c;
    assign bus.imem_addr  = idx_q;
    assign bus.imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised image loads checked against a queue-based model of the expected
// memory writes and final status.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int ALL    = 1 << 30;

    logic clk = 1'b0;
    logic reset, start;
    logic cpu_reset, busy, done, error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream_q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle: writes must match the model queue in order, and status must stay coherent.
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                chk("we_in_reset", {31'b0, bus.imem_we}, 32'd0);
            end else begin
                chk("cpu_reset_vs_done", {31'b0, cpu_reset}, {31'b0, !done});
                if (done || error) chk("ready_when_stopped", {31'b0, bus.byte_ready}, 32'd0);
                if (bus.imem_we) begin
                    wr_t w;
                    chk("ready_in_write", {31'b0, bus.byte_ready}, 32'd0);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                                 bus.imem_addr, bus.imem_wdata);
                    end else begin
                        w = exp_q.pop_front();
                        chk("wr_addr", 32'(bus.imem_addr), w.addr);
                        chk("wr_data", bus.imem_wdata, w.data);
                    end
                end
            end
        end
    end

    task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        foreach (stream_q[i]) s = s + stream_q[i];
        stream_q.push_back(8'h00 - s);
`endif
    endtask

    task automatic build_image(input int n);
        logic [31:0] w;
        logic [15:0] nn;
        nn = n[15:0];
        stream_q.push_back(nn[15:8]);
        stream_q.push_back(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            stream_q.push_back(w[31:24]);
            stream_q.push_back(w[23:16]);
            stream_q.push_back(w[15:8]);
            stream_q.push_back(w[7:0]);
            exp_q.push_back('{i, w});
        end
        finish_image();
    endtask

    task automatic drive(input int gap, input int limit, input int budget);
        int sent = 0;
        int cyc  = 0;
        while (sent < limit && stream_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if ($urandom_range(99) < gap) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = stream_q[0];
                if (bus.byte_ready) begin
                    void'(stream_q.pop_front());
                    sent++;
                end
            end
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        if (cyc >= budget) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout: sent %0d bytes, %0d still queued", sent, stream_q.size());
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'b0, busy}, 32'd1);
        chk("start_done", {31'b0, done}, 32'd0);
        chk("start_error", {31'b0, error}, 32'd0);
        chk("start_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    endtask

    task automatic wait_status(input bit exp_done, input int budget);
        int c = 0;
        while (!(done || error) && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        chk("final_done", {31'b0, done}, {31'b0, exp_done});
        chk("final_error", {31'b0, error}, {31'b0, !exp_done});
        chk("final_cpu_reset", {31'b0, cpu_reset}, {31'b0, !exp_done});
        chk("final_busy", {31'b0, busy}, 32'd0);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        stream_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] lit[$];
        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_byte_ready", {31'b0, bus.byte_ready}, 32'd0);
        chk("rst_imem_we", {31'b0, bus.imem_we}, 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_imem_wdata", bus.imem_wdata, 32'd0);
        chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Hand-computed two-word image, back-to-back then with gaps.
        lit = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        for (int g = 0; g < 2; g++) begin
            pulse_start();
            stream_q = lit;
            finish_image();
            exp_q.push_back('{0, 32'h2008_0005});
            exp_q.push_back('{1, 32'h2009_0007});
            drive(g * 50, ALL, 2000);
            wait_status(1'b1, 50);
        end

        // Zero-length header aborts without any write; a good image then recovers.
        pulse_start();
        stream_q = '{8'h00, 8'h00};
        drive(0, ALL, 100);
        wait_status(1'b0, 20);
        pulse_start();
        build_image(1);
        drive(30, ALL, 500);
        wait_status(1'b1, 50);

        // Full-capacity image, then one word too many.
        pulse_start();
        build_image(256);
        drive(0, ALL, 4000);
        wait_status(1'b1, 50);
        pulse_start();
        stream_q = '{8'h01, 8'h01};
        drive(0, ALL, 100);
        wait_status(1'b0, 20);

        // Reset after six data bytes: only word 0 may have been written.
        pulse_start();
        build_image(3);
        drive(30, 8, 500);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_writes_left", 32'(exp_q.size()), 32'd2);
        chk("midrst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_ready", {31'b0, bus.byte_ready}, 32'd0);
        chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
        exp_q.delete();
        stream_q.delete();

        // A start pulse in the middle of a load must not disturb it.
        pulse_start();
        build_image(4);
        drive(25, 7, 500);
        pulse_start();
        drive(25, ALL, 1000);
        wait_status(1'b1, 50);

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(20, 1);
            pulse_start();
            build_image(n);
            drive($urandom_range(60), ALL, 3000);
            wait_status(1'b1, 50);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            stream_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
            stream_q.push_back((k == 0) ? 8'hFF : 8'h00);
            exp_q.push_back('{0, 32'h0000_0000});
            drive(0, ALL, 100);
            wait_status(k == 0, 20);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
